// File: rtl/param_updown_counter_pkg.sv
// Shared definitions for the up/down counter and its prescaler.
package cnt_pkg;
   localparam int PRESCALE_MAX = 256;
   localparam int PRESC_W      = $clog2(PRESCALE_MAX + 1);

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;
endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle between the counter and whatever drives it.
interface param_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             sat_mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_flag;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;

   modport master (
      output en, up_dn, sat_mode, load, load_val, clr_flag,
      input  count, tc, ovf
   );

   modport slave (
      input  en, up_dn, sat_mode, load, load_val, clr_flag,
      output count, tc, ovf
   );
endinterface

// File: rtl/param_updown_counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the cycle a count step happens.
module tick_prescaler
   import cnt_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESCALE - 1);

   logic [PRESC_W-1:0] cnt;

   // clr wins over en so a load both restarts the period and never steps
   assign tick = en && !clr && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en)
         cnt <= tick ? '0 : cnt + PRESC_W'(1);
   end
endmodule

// File: rtl/param_updown_counter.sv
// Prescaled up/down counter with wrap/saturate boundary, terminal-count pulse and sticky overflow.
module param_updown_counter
   import cnt_pkg::*;
#(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] MAX      = '1,
   parameter int               PRESCALE = 1
) (
   input logic clk,
   input logic rst,
   param_updown_counter_if.slave bus
);
   logic             tick;
   logic             boundary;
   logic [WIDTH-1:0] nxt;
   mode_e            mode;

   assign mode = mode_e'(bus.sat_mode);

   tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.en),
      .clr  (bus.load),
      .tick (tick)
   );

   always_comb begin
      boundary = 1'b0;
      nxt      = bus.count;
      if (bus.up_dn) begin
         if (bus.count >= MAX) begin
            boundary = 1'b1;
            nxt      = (mode == MODE_SAT) ? MAX : '0;
         end else begin
            nxt = bus.count + WIDTH'(1);
         end
      end else begin
         if (bus.count == '0) begin
            boundary = 1'b1;
            nxt      = (mode == MODE_SAT) ? '0 : MAX;
         end else begin
            nxt = bus.count - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.count <= '0;
         bus.tc    <= 1'b0;
         bus.ovf   <= 1'b0;
      end else begin
         bus.tc <= 1'b0;
         if (bus.load)
            bus.count <= (bus.load_val > MAX) ? MAX : bus.load_val;
         else if (tick) begin
            bus.count <= nxt;
            bus.tc    <= boundary;
         end
         // a boundary step in the same cycle as clr_flag keeps the flag set
         if (tick && boundary)
            bus.ovf <= 1'b1;
         else if (bus.clr_flag)
            bus.ovf <= 1'b0;
      end
   end
endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (2..32).
REQ-002 Parameter MAX, default 2**WIDTH-1, terminal value; legal range 1..2**WIDTH-1.
REQ-003 Parameter PRESCALE, default 1, enabled cycles per count step (1..256).
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port en  input  1  count enable; gates the prescaler and the count step.
REQ-007 Port up_dn  input  1  direction; 1 = up, 0 = down.
REQ-008 Port sat_mode  input  1  boundary mode; 0 = wrap, 1 = saturate.
REQ-009 Port load  input  1  synchronous parallel load strobe.
REQ-010 Port load_val  input  WIDTH  value to load.
REQ-011 Port clr_flag  input  1  clears sticky ovf.
REQ-012 Port count  output  WIDTH  current count, registered.
REQ-013 Port tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-014 Port ovf  output  1  sticky boundary-crossing flag, registered.

Function
REQ-015 Priority per edge SHALL be rst > load > count step > hold.
REQ-016 load SHALL set count to min(load_val, MAX) on the next edge, reset the prescaler to 0, and suppress tc for that cycle.
REQ-017 Prescaler SHALL advance only when en=1 and load=0; a step SHALL occur on the enabled cycle on which it reaches PRESCALE-1, after which it SHALL return to 0.
REQ-018 With PRESCALE=1, a step SHALL occur on every cycle with en=1.
REQ-019 Step up with count<MAX SHALL give count+1; step down with count>0 SHALL give count-1.
REQ-020 Step up at count==MAX SHALL give 0 when sat_mode=0 and hold MAX when sat_mode=1.
REQ-021 Step down at count==0 SHALL give MAX when sat_mode=0 and hold 0 when sat_mode=1.
REQ-022 A boundary step (REQ-020/021) SHALL assert tc for exactly the following cycle in either mode.
REQ-023 A boundary step SHALL set ovf on the same edge as tc.
REQ-024 ovf SHALL clear on the edge after clr_flag=1; when clr_flag coincides with a boundary step, the set SHALL win.
REQ-025 Latency SHALL be one clock from sampled inputs to count, tc and ovf.
REQ-026 Direction or mode changes SHALL take effect on the step that samples them; no prescaler restart.
REQ-027 en=0 SHALL freeze count and prescaler, and SHALL drive tc to 0.

Reset
REQ-028 rst=1 SHALL set count=0, tc=0, ovf=0 and prescaler=0 on the next edge, overriding load, en and clr_flag.
REQ-029 rst asserted mid-count SHALL abort any pending prescaler progress; counting SHALL restart from 0 with a full PRESCALE period.

Structure
REQ-030 Shared package cnt_pkg SHALL hold localparam PRESC_W = $clog2(PRESCALE_MAX+1) and the boundary-mode enum (MODE_WRAP, MODE_SAT).
REQ-031 The prescaler SHALL be the sub-module tick_prescaler (ports clk, rst, en, clr, tick).
REQ-032 No combinational path SHALL run from inputs to outputs.

Verification
REQ-033 WIDTH=4 defaults: rst 2 cycles, then en=1, up_dn=1 -> count 0..15, then 0; tc=1 for the one cycle count=0 follows 15; ovf=1 thereafter.
REQ-034 sat_mode=1, up at 15 for 3 cycles -> count holds 15; tc pulses once per boundary step; ovf=1.
REQ-035 MAX=9: load 12 -> count=9; up_dn=0 from load 0 -> 9 with tc pulse.
REQ-036 PRESCALE=3: en=1 held -> count increments every 3rd cycle; en=0 for 2 cycles mid-period -> period stretches by 2.
REQ-037 clr_flag coincident with a 15->0 step -> ovf stays 1; clr_flag on a later quiet cycle -> ovf=0.
REQ-038 rst at count=7 during load=1 -> count=0, tc=0, ovf=0; next step at PRESCALE cycles after rst release.
